intrpt_cntrl_mode: RTL and testbench

Parametrised successor interrupt controller: `NUM_PHES` peripheral interrupt lines, each with a programmable priority, an enable bit and an edge/level mode bit, all configured over a one-wait-state APB slave port. A single-grant arbiter presents the highest-priority enabled pending source to the processor and holds it until the processor acknowledges service. It sits between the peripheral interrupt lines and the processor's interrupt input.

---
 rtl/intrpt_cntrl_mode.sv | 229 ++++++++++++++++++++++
 tb/tb_intrpt_cntrl_mode.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intrpt_cntrl_mode.sv
// intrpt_cntrl_mode: prioritised interrupt controller with edge/level
// sources, APB register port and a single-grant handshake to the core.
module intrpt_cntrl_mode #(
    parameter int NUM_PHES   = 16,
    parameter int PRI_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_PHES + 4),
    parameter int ID_WIDTH   = $clog2(NUM_PHES)
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic                  pready_o,
    output logic                  perror_o,
    output logic [DATA_WIDTH-1:0] prdata_o,
    input  logic [NUM_PHES-1:0]   intr_active_i,
    output logic                  intr_valid_o,
    output logic [ID_WIDTH-1:0]   intrt_to_be_serviced_o,
    input  logic                  intrt_serviced_i
);

    localparam logic [ADDR_WIDTH-1:0] A_ENABLE  = ADDR_WIDTH'(NUM_PHES);
    localparam logic [ADDR_WIDTH-1:0] A_MODE    = ADDR_WIDTH'(NUM_PHES + 1);
    localparam logic [ADDR_WIDTH-1:0] A_PENDING = ADDR_WIDTH'(NUM_PHES + 2);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(NUM_PHES + 3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e                             state_q, state_d;
    logic [ID_WIDTH-1:0]                id_q, id_d;

    logic [NUM_PHES-1:0][PRI_WIDTH-1:0] pri_q, pri_d;
    logic [NUM_PHES-1:0]                enable_q, enable_d;
    logic [NUM_PHES-1:0]                mode_q, mode_d;
    logic [NUM_PHES-1:0]                edge_pend_q, edge_pend_d;
    logic [NUM_PHES-1:0]                sample_q, sample_d;

    logic                               pready_q, pready_d;
    logic                               perror_q, perror_d;
    logic [DATA_WIDTH-1:0]              prdata_q, prdata_d;

    logic                               apb_access;
    logic                               wr_en;
    logic                               rd_en;
    logic                               addr_pri;
    logic                               addr_en;
    logic                               addr_mode;
    logic                               addr_pend;
    logic                               addr_stat;
    logic                               addr_err;
    logic [ID_WIDTH-1:0]                pri_idx;
    logic [DATA_WIDTH-1:0]              rdata;

    logic [NUM_PHES-1:0]                rise;
    logic [NUM_PHES-1:0]                pend_eff;
    logic [NUM_PHES-1:0]                req;
    logic [NUM_PHES-1:0]                wr_clr;
    logic [NUM_PHES-1:0]                ack_clr;

    logic                               win_found;
    logic [ID_WIDTH-1:0]                win_id;
    logic [PRI_WIDTH-1:0]               win_pri;

    logic                               unused_pwdata;

    // Only part of the write bus is meaningful for any register.
    assign unused_pwdata = ^pwdata_i;

    // The access edge is the first access cycle; the pready cycle is not.
    assign apb_access = psel_i & penable_i & ~pready_q;
    assign wr_en      = apb_access & pwrite_i;
    assign rd_en      = apb_access & ~pwrite_i;

    // Word address decode into the register map.
    always_comb begin
        addr_pri  = (paddr_i < A_ENABLE);
        addr_en   = (paddr_i == A_ENABLE);
        addr_mode = (paddr_i == A_MODE);
        addr_pend = (paddr_i == A_PENDING);
        addr_stat = (paddr_i == A_STATUS);
        addr_err  = ~(addr_pri | addr_en | addr_mode | addr_pend | addr_stat);
        pri_idx   = paddr_i[ID_WIDTH-1:0];
    end

    // Edge bits come from the latch, level bits are the live line.
    always_comb begin
        rise     = intr_active_i & ~sample_q;
        pend_eff = (edge_pend_q & mode_q) | (intr_active_i & ~mode_q);
        req      = pend_eff & enable_q;
    end

    // Highest priority wins; strict compare keeps the lowest index on ties.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_pri   = '0;
        for (int n = 0; n < NUM_PHES; n++) begin
            if (req[n] && (!win_found || pri_q[n] > win_pri)) begin
                win_found = 1'b1;
                win_id    = ID_WIDTH'(n);
                win_pri   = pri_q[n];
            end
        end
    end

    // Grant FSM state register.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q <= S_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // Grant FSM next state; the id is latched once and held through GRANT.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = '0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    id_d    = win_id;
                end
            end
            S_GRANT: begin
                if (intrt_serviced_i) begin
                    state_d      = S_GAP;
                    ack_clr[id_q] = 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant FSM outputs.
    always_comb begin
        intr_valid_o           = (state_q == S_GRANT);
        intrt_to_be_serviced_o = id_q;
    end

    // Configuration writes and edge pending update; a new edge beats any clear.
    always_comb begin
        pri_d    = pri_q;
        enable_d = enable_q;
        mode_d   = mode_q;
        wr_clr   = '0;
        if (wr_en) begin
            if (addr_pri) begin
                pri_d[pri_idx] = pwdata_i[PRI_WIDTH-1:0];
            end else if (addr_en) begin
                enable_d = pwdata_i[NUM_PHES-1:0];
            end else if (addr_mode) begin
                mode_d = pwdata_i[NUM_PHES-1:0];
            end else if (addr_pend) begin
                wr_clr = pwdata_i[NUM_PHES-1:0];
            end
        end
        edge_pend_d = (edge_pend_q & ~wr_clr & ~ack_clr) | (rise & mode_q);
        sample_d    = intr_active_i;
    end

    // Read mux; unmapped addresses and unused bits return zero.
    always_comb begin
        rdata = '0;
        if (addr_pri) begin
            rdata[PRI_WIDTH-1:0] = pri_q[pri_idx];
        end else if (addr_en) begin
            rdata[NUM_PHES-1:0] = enable_q;
        end else if (addr_mode) begin
            rdata[NUM_PHES-1:0] = mode_q;
        end else if (addr_pend) begin
            rdata[NUM_PHES-1:0] = pend_eff;
        end else if (addr_stat) begin
            rdata[ID_WIDTH:0] = {state_q == S_GRANT, id_q};
        end
    end

    // APB response is captured at the access edge and shown for one cycle.
    always_comb begin
        pready_d = apb_access;
        perror_d = apb_access & addr_err;
        prdata_d = rd_en ? rdata : '0;
    end

    // Configuration, pending and APB response registers.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            pri_q       <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            edge_pend_q <= '0;
            sample_q    <= '0;
            pready_q    <= 1'b0;
            perror_q    <= 1'b0;
            prdata_q    <= '0;
        end else begin
            pri_q       <= pri_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            edge_pend_q <= edge_pend_d;
            sample_q    <= sample_d;
            pready_q    <= pready_d;
            perror_q    <= perror_d;
            prdata_q    <= prdata_d;
        end
    end

    assign pready_o = pready_q;
    assign perror_o = perror_q;
    assign prdata_o = prdata_q;

endmodule

// File: tb/tb_intrpt_cntrl_mode.sv
// tb_intrpt_cntrl_mode: scoreboard bench for the interrupt controller,
// directed scenarios followed by randomised priority/mode/enable mixes.
module tb_intrpt_cntrl_mode;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int AW = $clog2(N + 4);
    localparam int IW = $clog2(N);

    localparam int A_EN   = N;
    localparam int A_MODE = N + 1;
    localparam int A_PEND = N + 2;
    localparam int A_STAT = N + 3;
    localparam int A_BAD  = N + 5;

    logic          clk = 1'b0;
    logic          prst;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic          perror;
    logic [DW-1:0] prdata;
    logic [N-1:0]  act;
    logic          valid;
    logic [IW-1:0] id;
    logic          ack;

    always #5 clk = ~clk;

    intrpt_cntrl_mode dut (
        .pclk_i                 (clk),
        .prst_i                 (prst),
        .psel_i                 (psel),
        .penable_i              (penable),
        .pwrite_i               (pwrite),
        .paddr_i                (paddr),
        .pwdata_i               (pwdata),
        .pready_o               (pready),
        .perror_o               (perror),
        .prdata_o               (prdata),
        .intr_active_i          (act),
        .intr_valid_o           (valid),
        .intrt_to_be_serviced_o (id),
        .intrt_serviced_i       (ack)
    );

    typedef struct {
        bit          chk;
        bit          err;
        logic [31:0] data;
    } apb_exp_t;

    int       vectors    = 0;
    int       miscompares = 0;
    int       grant_q[$];
    apb_exp_t apb_q[$];

    bit [N-1:0] mode_m;
    int         pri_m[N];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail(string name, string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: pops expected grants and APB responses as the DUT shows them.
    bit            prev_v = 1'b0;
    logic [IW-1:0] prev_id = '0;
    int            e_id;
    apb_exp_t      e_apb;

    always @(negedge clk) begin
        if (valid && !prev_v) begin
            if (grant_q.size() == 0) begin
                fail("unexpected_grant", $sformatf("got id %0d, required none", id));
            end else begin
                e_id = grant_q.pop_front();
                check("grant_id", 32'(id), 32'(e_id));
            end
        end
        if (valid && prev_v) begin
            check("grant_id_stable", 32'(id), 32'(prev_id));
        end
        if (pready) begin
            if (apb_q.size() == 0) begin
                fail("unexpected_pready", "no transfer outstanding");
            end else begin
                e_apb = apb_q.pop_front();
                check("apb_perror", 32'(perror), 32'(e_apb.err));
                if (e_apb.chk) begin
                    check("apb_prdata", prdata, e_apb.data);
                end
            end
        end
        prev_v  = valid;
        prev_id = id;
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb(bit wr, int addr, logic [31:0] wd,
                       bit exp_err, logic [31:0] exp_d, bit chk);
        apb_exp_t t;
        int k;
        t.chk  = chk;
        t.err  = exp_err;
        t.data = exp_d;
        apb_q.push_back(t);
        tick();
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = AW'(addr);
        pwdata  = wd;
        tick();
        penable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pready && k < 8);
        if (!pready) fail("apb_timeout", "pready never rose");
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        check("pready_one_cycle", 32'(pready), 32'd0);
    endtask

    task automatic wr(int addr, logic [31:0] d);
        apb(1'b1, addr, d, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic rd(int addr, logic [31:0] exp, bit err = 1'b0);
        apb(1'b0, addr, 32'd0, err, exp, 1'b1);
    endtask

    task automatic wait_valid(output bit ok);
        int k;
        k = 0;
        while (!valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        ok = valid;
        if (!ok) fail("grant_timeout", "intr_valid_o never rose");
    endtask

    task automatic ack_pulse(bit drop);
        logic [IW-1:0] g;
        g   = id;
        ack = 1'b1;
        if (drop && !mode_m[g]) act[g] = 1'b0;
        tick();
        ack = 1'b0;
    endtask

    task automatic serve(int n, bit drop);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_valid(ok);
            if (!ok) return;
            tick($urandom_range(0, 3));
            ack_pulse(drop);
        end
    endtask

    // Expected service order: priority descending, index ascending.
    task automatic push_order(logic [N-1:0] set, output int cnt);
        logic [N-1:0] rem;
        int best;
        int bk;
        rem = set;
        cnt = 0;
        while (rem != '0) begin
            best = -1;
            bk   = -1;
            for (int n = 0; n < N; n++) begin
                if (rem[n] && (pri_m[n] * N + (N - 1 - n)) > bk) begin
                    bk   = pri_m[n] * N + (N - 1 - n);
                    best = n;
                end
            end
            grant_q.push_back(best);
            rem[best] = 1'b0;
            cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit           ok;
        int           cnt;
        logic [N-1:0] act_set;
        logic [N-1:0] en;

        prst    = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        act     = '0;
        ack     = 1'b0;
        mode_m  = '0;
        for (int n = 0; n < N; n++) pri_m[n] = 0;
        tick(3);
        prst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_id", 32'(id), 32'd0);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_perror", 32'(perror), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        rd(A_EN, 32'd0);
        rd(A_MODE, 32'd0);
        rd(0, 32'd0);

        // Priority order with level lines.
        for (int n = 0; n < N; n++) begin
            pri_m[n] = n;
            wr(n, 32'(n));
        end
        wr(A_EN, 32'hFFFF);
        wr(A_MODE, 32'h0);
        grant_q.push_back(7);
        grant_q.push_back(5);
        grant_q.push_back(2);
        grant_q.push_back(0);
        act = 16'h00A5;
        serve(4, 1'b1);

        // Tie-break: equal priority, lowest index first.
        pri_m[3] = 6;
        pri_m[9] = 6;
        wr(3, 32'd6);
        wr(9, 32'd6);
        grant_q.push_back(3);
        grant_q.push_back(9);
        act[3] = 1'b1;
        act[9] = 1'b1;
        serve(2, 1'b1);

        // Edge mode: single pulse, then a held line that must not re-grant.
        wr(A_MODE, 32'h10);
        mode_m = 16'h0010;
        grant_q.push_back(4);
        tick();
        act[4] = 1'b1;
        tick();
        act[4] = 1'b0;
        serve(1, 1'b0);
        rd(A_PEND, 32'h0);
        tick();
        grant_q.push_back(4);
        act[4] = 1'b1;
        serve(1, 1'b0);
        tick(10);
        rd(A_PEND, 32'h0);
        act[4] = 1'b0;

        // Write-1 clear of an edge pending bit.
        wr(A_EN, 32'h0);
        tick();
        act[4] = 1'b1;
        tick();
        act[4] = 1'b0;
        rd(A_PEND, 32'h10);
        wr(A_PEND, 32'h10);
        rd(A_PEND, 32'h0);
        wr(A_EN, 32'hFFFF);
        wr(A_MODE, 32'h0);
        mode_m = '0;

        // Masking the granted source does not revoke the grant.
        grant_q.push_back(5);
        act[5] = 1'b1;
        wait_valid(ok);
        wr(A_EN, 32'hFFDF);
        check("held_valid", 32'(valid), 32'd1);
        check("held_id", 32'(id), 32'd5);
        ack_pulse(1'b0);
        tick(10);
        check("masked_no_regrant", 32'(valid), 32'd0);
        act[5] = 1'b0;
        wr(A_EN, 32'hFFFF);

        // STATUS during a grant on 7, then APB error accesses.
        grant_q.push_back(7);
        act[7] = 1'b1;
        wait_valid(ok);
        rd(A_STAT, 32'h17);
        ack_pulse(1'b1);
        rd(A_BAD, 32'h0, 1'b1);
        apb(1'b1, A_BAD, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
        rd(A_EN, 32'hFFFF);

        // Reset in the middle of a grant.
        grant_q.push_back(7);
        act[7] = 1'b1;
        wait_valid(ok);
        tick();
        prst = 1'b1;
        tick();
        prst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_id", 32'(id), 32'd0);
        check("midrst_pready", 32'(pready), 32'd0);
        check("midrst_prdata", prdata, 32'd0);
        for (int n = 0; n < N; n++) pri_m[n] = 0;
        rd(A_EN, 32'd0);
        rd(A_MODE, 32'd0);
        rd(7, 32'd0);
        tick(10);
        wr(A_EN, 32'h80);
        grant_q.push_back(7);
        serve(1, 1'b1);
        act = '0;

        // Randomised priority / mode / enable mixes.
        for (int s = 0; s < 15; s++) begin
            wr(A_EN, 32'h0);
            wr(A_PEND, 32'hFFFF);
            for (int n = 0; n < N; n++) begin
                pri_m[n] = $urandom_range(0, 15);
                wr(n, 32'(pri_m[n]));
            end
            mode_m  = N'($urandom);
            act_set = N'($urandom);
            en      = N'($urandom);
            wr(A_MODE, 32'(mode_m));
            tick();
            act = act_set;
            tick();
            act = act_set & ~mode_m;
            tick();
            push_order(act_set & en, cnt);
            wr(A_EN, 32'(en));
            serve(cnt, 1'b1);
            tick(5);
            check("queue_drained", 32'(grant_q.size()), 32'd0);
            act = '0;
            wr(A_EN, 32'h0);
        end

        tick(5);
        check("grant_q_empty", 32'(grant_q.size()), 32'd0);
        check("apb_q_empty", 32'(apb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
